// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32 decode stage with a single registered output slot,
//            valid/ready handshake, early JAL redirect to fetch and
//            prioritised execute-stage redirect.
// Revision : 1.0 - initial release
// ============================================================================

package decode_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;
endpackage

module decode_stage #(
    parameter type F         = decode_stage_pkg::fetch_t,
    parameter int  JAL_EARLY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // fetch side
    input  logic        valid_prod_i,
    output logic        ready_prod_o,
    input  F            data_i,
    // execute-stage redirect
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_redirect_pc_i,
    // redirect to fetch
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    // decoded output
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic       JAL_EN      = (JAL_EARLY == 1);

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_REG      = 7'b0110011;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [31:0] imm_q, imm_d;
    logic        illegal_q, illegal_d;

    logic [63:0] w_data;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_ready;
    logic        w_fire;
    logic        w_jal_take;

    // The bundle is {pc, instr}; slice it as a flat vector.
    assign w_data   = data_i;
    assign w_pc     = w_data[63:32];
    assign w_instr  = w_data[31:0];
    assign w_opcode = w_instr[6:0];

    // Immediate generation and legality check for the incoming word.
    always_comb begin
        w_imm     = 32'd0;
        w_illegal = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            OP_STORE:
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            OP_BRANCH:
                w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                         w_instr[30:25], w_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {w_instr[31:12], 12'd0};
            OP_JAL:
                w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                         w_instr[20], w_instr[30:21], 1'b0};
            OP_REG:
                w_imm = 32'd0;
            default:
                w_illegal = 1'b1;
        endcase
        // Every legal opcode already ends in 2'b11; the explicit check keeps
        // the rule obvious.
        if (w_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    // Accept only into a free (or draining) slot, never during a redirect.
    assign w_ready    = !reset_i && (!valid_q || ready_i) && !ex_redirect_i
                        && (state_q == RUN);
    assign w_fire     = valid_prod_i && w_ready;
    assign w_jal_take = JAL_EN && w_fire && (w_opcode == OP_JAL);

    assign ready_prod_o = w_ready;

    // Redirect FSM next state: one REDIR cycle after an accepted JAL.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            RUN: begin
                if (w_jal_take) begin
                    state_d  = REDIR;
                    target_d = w_pc + w_imm;
                end
            end
            REDIR: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Execute redirect cancels any pending decode redirect.
        if (ex_redirect_i) begin
            state_d = RUN;
        end
    end

    // Redirect outputs: execute target wins; address is zero when idle.
    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = 32'd0;
        if (!reset_i) begin
            if (ex_redirect_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = ex_redirect_pc_i;
            end else if (state_q == REDIR) begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
            end
        end
    end

    // Output slot next state: load on fire, drain on ready, flush on redirect.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (ex_redirect_i) begin
            valid_d = 1'b0;
        end else if (w_fire) begin
            valid_d   = 1'b1;
            pc_d      = w_pc;
            opcode_d  = w_opcode;
            rd_d      = w_instr[11:7];
            funct3_d  = w_instr[14:12];
            rs1_d     = w_instr[19:15];
            rs2_d     = w_instr[24:20];
            funct7_d  = w_instr[31:25];
            imm_d     = w_imm;
            illegal_d = w_illegal;
        end else if (ready_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // FSM state and latched JAL target.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= RUN;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Registered decode outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q   <= 1'b0;
            pc_q      <= 32'd0;
            opcode_q  <= 7'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            imm_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign opcode_o  = opcode_q;
    assign rd_o      = rd_q;
    assign rs1_o     = rs1_q;
    assign rs2_o     = rs2_q;
    assign funct3_o  = funct3_q;
    assign funct7_o  = funct7_q;
    assign imm_o     = imm_q;
    assign illegal_o = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage: reference model plus
//            directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================

module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_prod_i = 1'b0;
    logic        ready_prod_o;
    decode_stage_pkg::fetch_t data_i = '0;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_redirect_pc_i = 32'd0;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int errors = 0;
    int checks = 0;

    decode_stage #(
        .F         (decode_stage_pkg::fetch_t),
        .JAL_EARLY (1)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .valid_prod_i     (valid_prod_i),
        .ready_prod_o     (ready_prod_o),
        .data_i           (data_i),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .opcode_o         (opcode_o),
        .rd_o             (rd_o),
        .rs1_o            (rs1_o),
        .rs2_o            (rs2_o),
        .funct3_o         (funct3_o),
        .funct7_o         (funct7_o),
        .imm_o            (imm_o),
        .illegal_o        (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: immediates from signed integer arithmetic.
    function automatic void m_dec(input logic [31:0] w, output logic [31:0] imm,
                                  output logic ill);
        int v;
        imm = 32'd0;
        ill = 1'b0;
        v   = 0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin v = $signed(w[31:20]); imm = v; end
            7'h23: begin v = $signed({w[31:25], w[11:7]}); imm = v; end
            7'h63: begin v = $signed({w[31], w[7], w[30:25], w[11:8]}); imm = v * 2; end
            7'h37, 7'h17: imm = w & 32'hFFFF_F000;
            7'h6F: begin v = $signed({w[31], w[19:12], w[20], w[30:21]}); imm = v * 2; end
            7'h33: imm = 32'd0;
            default: ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
    endfunction

    // Model state
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_imm = 32'd0;
    logic        m_ill = 1'b0;
    logic        m_redir = 1'b0;
    logic [31:0] m_target = 32'd0;

    function automatic logic m_ready();
        return !reset_i && (!m_valid || ready_i) && !ex_redirect_i && !m_redir;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        logic [31:0] imm;
        logic        ill;
        if (reset_i) begin
            m_valid  <= 1'b0;
            m_pc     <= 32'd0;
            m_instr  <= 32'd0;
            m_imm    <= 32'd0;
            m_ill    <= 1'b0;
            m_redir  <= 1'b0;
            m_target <= 32'd0;
        end else if (ex_redirect_i) begin
            m_valid <= 1'b0;
            m_redir <= 1'b0;
        end else begin
            m_redir <= 1'b0;
            if (valid_prod_i && m_ready()) begin
                m_dec(data_i.instr, imm, ill);
                m_valid <= 1'b1;
                m_pc    <= data_i.pc;
                m_instr <= data_i.instr;
                m_imm   <= imm;
                m_ill   <= ill;
                if (data_i.instr[6:0] == 7'h6F) begin
                    m_redir  <= 1'b1;
                    m_target <= data_i.pc + imm;
                end
            end else if (ready_i) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk_i) begin
        logic [31:0] e_rpc;
        e_rpc = reset_i ? 32'd0 : ex_redirect_i ? ex_redirect_pc_i :
                m_redir ? m_target : 32'd0;
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        chk("ready_prod_o", {31'd0, ready_prod_o}, {31'd0, m_ready()});
        chk("redirect_o", {31'd0, redirect_o},
            {31'd0, !reset_i && (ex_redirect_i || m_redir)});
        chk("redirect_pc_o", redirect_pc_o, e_rpc);
        chk("pc_o", pc_o, m_pc);
        chk("opcode_o", {25'd0, opcode_o}, {25'd0, m_instr[6:0]});
        chk("rd_o", {27'd0, rd_o}, {27'd0, m_instr[11:7]});
        chk("funct3_o", {29'd0, funct3_o}, {29'd0, m_instr[14:12]});
        chk("rs1_o", {27'd0, rs1_o}, {27'd0, m_instr[19:15]});
        chk("rs2_o", {27'd0, rs2_o}, {27'd0, m_instr[24:20]});
        chk("funct7_o", {25'd0, funct7_o}, {25'd0, m_instr[31:25]});
        chk("imm_o", imm_o, m_imm);
        chk("illegal_o", {31'd0, illegal_o}, {31'd0, m_ill});
    end

    // Drive inputs 2 time units after a rising edge, return at the falling edge.
    task automatic apply(input logic vp, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic exr, input logic [31:0] expc);
        @(posedge clk_i);
        #2;
        valid_prod_i     = vp;
        data_i.pc        = pc;
        data_i.instr     = instr;
        ready_i          = rdy;
        ex_redirect_i    = exr;
        ex_redirect_pc_i = expc;
        @(negedge clk_i);
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD  = 32'h0020_80B3;
    localparam logic [31:0] LUI  = 32'h1234_50B7;
    localparam logic [31:0] JAL  = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ  = 32'h8000_0063;
    localparam logic [31:0] SW   = 32'hFE00_2FA3;
    localparam logic [31:0] BAD  = 32'h0000_007F;

    initial begin
        // Reset state
        #12;
        chk("rst valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst ready_prod_o", {31'd0, ready_prod_o}, 32'd0);
        chk("rst redirect_pc_o", redirect_pc_o, 32'd0);
        @(negedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);

        // addi x1,x0,5 at pc 0
        apply(1'b1, 32'h0, ADDI, 1'b1, 1'b0, 32'h0);
        chk("addi accept", {31'd0, ready_prod_o}, 32'd1);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("addi valid", {31'd0, valid_o}, 32'd1);
        chk("addi pc", pc_o, 32'h0);
        chk("addi rd", {27'd0, rd_o}, 32'd1);
        chk("addi imm", imm_o, 32'd5);
        chk("addi illegal", {31'd0, illegal_o}, 32'd0);

        // Backpressure for three cycles
        apply(1'b1, 32'h4, ADD, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h8, LUI, 1'b0, 1'b0, 32'h0);
            chk("stall ready_prod", {31'd0, ready_prod_o}, 32'd0);
            chk("stall pc", pc_o, 32'h4);
        end
        apply(1'b1, 32'h8, LUI, 1'b1, 1'b0, 32'h0);
        chk("release accept", {31'd0, ready_prod_o}, 32'd1);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("lui pc", pc_o, 32'h8);
        chk("lui imm", imm_o, 32'h1234_5000);

        // JAL x0,-8 at 0x20
        apply(1'b1, 32'h20, JAL, 1'b1, 1'b0, 32'h0);
        apply(1'b1, 32'h24, ADD, 1'b1, 1'b0, 32'h0);
        chk("jal fwd opcode", {25'd0, opcode_o}, 32'h6F);
        chk("jal redirect", {31'd0, redirect_o}, 32'd1);
        chk("jal target", redirect_pc_o, 32'h18);
        chk("jal redir ready", {31'd0, ready_prod_o}, 32'd0);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("jal pulse end", {31'd0, redirect_o}, 32'd0);
        chk("no wrong path", {31'd0, valid_o}, 32'd0);

        // JAL then execute redirect in the REDIR cycle
        apply(1'b1, 32'h20, JAL, 1'b1, 1'b0, 32'h0);
        apply(1'b1, 32'h24, ADD, 1'b0, 1'b1, 32'h100);
        chk("ex redirect pc", redirect_pc_o, 32'h100);
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ex flush valid", {31'd0, valid_o}, 32'd0);
        chk("ex no 0x18", {31'd0, redirect_o}, 32'd0);

        // Immediate corner cases and illegal opcode
        apply(1'b1, 32'h40, BEQ, 1'b1, 1'b0, 32'h0);
        apply(1'b1, 32'h44, SW, 1'b1, 1'b0, 32'h0);
        chk("beq imm", imm_o, 32'hFFFF_F000);
        apply(1'b1, 32'h48, BAD, 1'b1, 1'b0, 32'h0);
        chk("sw imm", imm_o, 32'hFFFF_FFFF);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bad illegal", {31'd0, illegal_o}, 32'd1);
        chk("bad forwarded", {31'd0, valid_o}, 32'd1);

        // Asynchronous reset during REDIR
        apply(1'b1, 32'h20, JAL, 1'b0, 1'b0, 32'h0);
        apply(1'b1, 32'h50, ADDI, 1'b0, 1'b0, 32'h0);
        chk("pre-rst redirect", {31'd0, redirect_o}, 32'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("async rst redirect", {31'd0, redirect_o}, 32'd0);
        chk("async rst rpc", redirect_pc_o, 32'd0);
        chk("async rst valid", {31'd0, valid_o}, 32'd0);
        chk("async rst ready", {31'd0, ready_prod_o}, 32'd0);
        apply(1'b1, 32'h60, ADDI, 1'b1, 1'b0, 32'h0);
        apply(1'b1, 32'h60, ADDI, 1'b1, 1'b0, 32'h0);
        chk("rst held no pulse", {31'd0, redirect_o}, 32'd0);
        #1 reset_i = 1'b0;
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("first fire valid", {31'd0, valid_o}, 32'd1);
        chk("first fire pc", pc_o, 32'h60);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter F, default fetch_t, which is the input bundle type and carries {pc[31:0], instr[31:0]}.
REQ-002 SHALL have parameter JAL_EARLY, default 1, which enables the decode-time JAL redirect when set to 1.
REQ-003 SHALL have ports: clk_i  in  1  the single clock; reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: valid_prod_i  in  1  fetch word valid; ready_prod_o  out  1  word accepted; data_i  in  F  {pc,instr}.
REQ-005 SHALL have ports: ex_redirect_i  in  1  execute mispredict; ex_redirect_pc_i  in  32  execute target.
REQ-006 SHALL have ports: redirect_o  out  1  to fetch redirect; redirect_pc_o  out  32  to fetch redirect pc.
REQ-007 SHALL have ports: valid_o  out  1; ready_i  in  1; pc_o  out  32; opcode_o  out  7; rd_o/rs1_o/rs2_o  out  5 each; funct3_o  out  3; funct7_o  out  7; imm_o  out  32; illegal_o  out  1.

Function
REQ-008 SHALL accept a word on the edge where valid_prod_i && ready_prod_o (a fire).
REQ-009 SHALL drive ready_prod_o = (!valid_o || ready_i) && !ex_redirect_i && state==RUN.
REQ-010 SHALL register decode results in a single output stage: on fire, valid_o<=1 and all fields update; on ready_i && valid_o with no fire, valid_o<=0; otherwise hold. Latency is 1 cycle.
REQ-011 SHALL keep all output fields stable while valid_o && !ready_i.
REQ-012 SHALL extract fields: opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-013 SHALL generate a sign-extended imm_o by opcode: I (0000011, 0010011, 1100111, 1110011), S (0100011), B (1100011), U (0110111, 0010111) = {instr[31:12],12'b0}, J (1101111); R (0110011) = 0.
REQ-014 SHALL set illegal_o=1 for any opcode outside REQ-013 or instr[1:0]!=2'b11; illegal words are still forwarded.
REQ-015 SHALL use an FSM with states RUN and REDIR.
REQ-016 SHALL, when JAL_EARLY=1 and a fire accepts opcode 1101111 in RUN with no ex_redirect_i: forward the JAL downstream, latch target = pc + J-imm (mod 2^32), and go to REDIR.
REQ-017 SHALL, in REDIR, drive redirect_o=1 and redirect_pc_o=the latched target for exactly one cycle with ready_prod_o=0, then return to RUN.
REQ-018 SHALL give ex_redirect_i priority: redirect_o=1 and redirect_pc_o=ex_redirect_pc_i combinationally in the same cycle.
REQ-019 SHALL, on ex_redirect_i, clear valid_o at the next edge, force state to RUN (cancelling any pending REDIR), and allow no fire that cycle.
REQ-020 SHALL drive redirect_pc_o=0 whenever redirect_o=0.
REQ-021 SHALL, when ex_redirect_i and REDIR coincide, output only the ex target and drop the decode redirect.
REQ-022 SHALL accept no second word between a JAL fire and the REDIR cycle, so that no wrong-path word reaches valid_o.
REQ-023 SHALL leave the JAL target unaligned-unchecked, passing bits[1:0] through as computed.

Reset
REQ-024 SHALL, while reset_i=1, asynchronously force valid_o=0, state=RUN, redirect_o=0, redirect_pc_o=0, and all registered fields and the latched target to 0.
REQ-025 SHALL, while reset_i=1, drive ready_prod_o=0; the first fire is possible on the first edge after reset_i falls.
REQ-026 SHALL, on reset asserted mid-REDIR, abort the pending redirect so that no redirect_o pulse follows.

Verification
REQ-027 SHALL cover: stream addi x1,x0,5 (0x00500093) at pc 0 with ready_i=1 -> next cycle valid_o=1, pc_o=0, rd_o=1, imm_o=5, illegal_o=0.
REQ-028 SHALL cover: hold ready_i=0 for 3 cycles with valid_o=1 -> outputs stable, ready_prod_o=0; release -> next word accepted the same cycle.
REQ-029 SHALL cover: JAL x0,-8 (0xFF9FF06F) at pc 0x20 -> JAL forwarded, next cycle redirect_o=1, redirect_pc_o=0x18 for exactly 1 cycle, ready_prod_o=0 in that cycle.
REQ-030 SHALL cover: JAL accepted, then ex_redirect_i=1 with pc 0x100 in the following cycle -> redirect_pc_o=0x100, no 0x18 pulse, valid_o=0 next cycle.
REQ-031 SHALL cover: B-type beq with imm -4096 and S-type sw with imm -1 -> imm_o=0xFFFFF000 and 0xFFFFFFFF; opcode 0x7F -> illegal_o=1.
REQ-032 SHALL cover: reset_i pulsed asynchronously in REDIR -> redirect_o drops immediately and valid_o=0 with no clock edge.
